// File: rtl/universal_shift_register_n.sv
// Universal N-bit shift register: shift, rotate, arithmetic, load, clear, burst.
// Define SHREG_PARITY_EN to add a registered PARITY output equal to ^Q.
module universal_shift_register_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [2:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [CNT_W-1:0] CNT,
  input  logic             START,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
`ifdef SHREG_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] M_SHIFT = 3'b000;
  localparam logic [2:0] M_ROT   = 3'b001;
  localparam logic [2:0] M_LOAD  = 3'b010;
  localparam logic [2:0] M_CLR   = 3'b011;
  localparam logic [2:0] M_ARITH = 3'b100;
  localparam logic [2:0] M_BURST = 3'b101;

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bdir, bdir_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             s_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] shl, shr;

  assign shl  = {Q[WIDTH-2:0], S_IN};
  assign shr  = {S_IN, Q[WIDTH-1:1]};
  assign BUSY = (st == RUN);

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    bdir_nxt = bdir;
    q_nxt    = Q;
    s_nxt    = S_OUT;
    done_nxt = 1'b0;
    if (st == RUN) begin
      q_nxt   = bdir ? shr : shl;
      s_nxt   = bdir ? Q[0] : Q[WIDTH-1];
      cnt_nxt = cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        st_nxt   = IDLE;
        done_nxt = 1'b1;
      end
    end else begin
      case (MODO)
        M_SHIFT: begin
          q_nxt = DIR ? shr : shl;
          s_nxt = DIR ? Q[0] : Q[WIDTH-1];
        end
        M_ROT: begin
          q_nxt = DIR ? {Q[0], Q[WIDTH-1:1]}
                      : {Q[WIDTH-2:0], Q[WIDTH-1]};
          s_nxt = 1'b0;
        end
        M_LOAD: begin
          q_nxt = D;
          s_nxt = 1'b0;
        end
        M_CLR: begin
          q_nxt = '0;
          s_nxt = 1'b0;
        end
        M_ARITH: begin
          q_nxt = DIR ? {Q[WIDTH-1], Q[WIDTH-1:1]}
                      : {Q[WIDTH-2:0], 1'b0};
          s_nxt = DIR ? Q[0] : Q[WIDTH-1];
        end
        M_BURST: begin
          // zero-length request completes at once without shifting
          if (START && CNT != '0) begin
            st_nxt   = RUN;
            cnt_nxt  = CNT;
            bdir_nxt = DIR;
          end else if (START) begin
            done_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st    <= IDLE;
      cnt   <= '0;
      bdir  <= 1'b0;
      Q     <= '0;
      S_OUT <= 1'b0;
      DONE  <= 1'b0;
    end else if (ENB) begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      bdir  <= bdir_nxt;
      Q     <= q_nxt;
      S_OUT <= s_nxt;
      DONE  <= done_nxt;
    end
  end

`ifdef SHREG_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) PARITY <= 1'b0;
    else if (ENB) PARITY <= ^q_nxt;
  end
`endif

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Randomised and directed check of universal_shift_register_n
// against an arithmetic reference model.
module tb_universal_shift_register_n;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enb;
  logic          dir;
  logic          s_in;
  logic [2:0]    modo;
  logic [W-1:0]  d;
  logic [CW-1:0] cnt;
  logic          start;
  logic [W-1:0]  q;
  logic          s_out;
  logic          busy;
  logic          done;
`ifdef SHREG_PARITY_EN
  logic          parity;
`endif

  int n_tests = 0;
  int n_fails = 0;

  logic [W-1:0] m_q;
  logic         m_sout;
  logic         m_busy;
  logic         m_done;
  logic         m_bdir;
  int           m_rem;

  always #5 clk = ~clk;

  universal_shift_register_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .ENB   (enb),
    .DIR   (dir),
    .S_IN  (s_in),
    .MODO  (modo),
    .D     (d),
    .CNT   (cnt),
    .START (start),
    .Q     (q),
    .S_OUT (s_out),
    .BUSY  (busy),
    .DONE  (done)
`ifdef SHREG_PARITY_EN
    ,
    .PARITY(parity)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_sout = 0; m_busy = 0;
    m_done = 0; m_bdir = 0; m_rem = 0;
  endtask

  // Register value treated as an unsigned integer in [0, 2**W)
  task automatic model_clock();
    int v, top, full, si;
    top  = 1 << (W - 1);
    full = 1 << W;
    v    = int'(m_q);
    si   = int'(s_in);
    if (!rst_n || !enb) return;
    if (m_busy) begin
      m_sout = m_bdir ? (v % 2 == 1) : (v >= top);
      v = m_bdir ? v / 2 + si * top : (v * 2 + si) % full;
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_busy = 0;
    end else begin
      m_done = 0;
      case (modo)
        3'd0: begin
          m_sout = dir ? (v % 2 == 1) : (v >= top);
          v = dir ? v / 2 + si * top : (v * 2 + si) % full;
        end
        3'd1: begin
          m_sout = 0;
          v = dir ? v / 2 + (v % 2) * top : (v * 2) % full + v / top;
        end
        3'd2: begin m_sout = 0; v = int'(d); end
        3'd3: begin m_sout = 0; v = 0; end
        3'd4: begin
          m_sout = dir ? (v % 2 == 1) : (v >= top);
          v = dir ? v / 2 + (v & top) : (v * 2) % full;
        end
        3'd5: begin
          if (start && cnt != 0) begin
            m_busy = 1; m_rem = int'(cnt); m_bdir = dir;
          end else if (start) begin
            m_done = 1;
          end
        end
        default: ;
      endcase
    end
    m_q = W'(v);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q"},    32'(q),     32'(m_q));
    check({tag, ".sout"}, 32'(s_out), 32'(m_sout));
    check({tag, ".busy"}, 32'(busy),  32'(m_busy));
    check({tag, ".done"}, 32'(done),  32'(m_done));
`ifdef SHREG_PARITY_EN
    check({tag, ".par"},  32'(parity), 32'(^m_q));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic drive(input logic [2:0] m, input logic dr,
                       input logic si, input logic [W-1:0] dd);
    modo = m; dir = dr; s_in = si; d = dd; start = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 model_reset();
    compare_all("rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [W-1:0] bits;
    int nb;
    rst_n = 1; enb = 1; dir = 0; s_in = 0;
    modo = 3'd6; d = '0; cnt = '0; start = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // reset aborts a burst without DONE
    drive(3'd2, 0, 0, 8'hA5); step("ld_a5");
    drive(3'd5, 0, 0, 8'h00); cnt = 4'd8; start = 1; step("bst");
    start = 0; modo = 3'd6;
    repeat (3) step("bst_run");
    do_reset();
    check("abort.q", 32'(q), 32'h0);
    repeat (4) step("post_abort");

    drive(3'd2, 0, 0, 8'h96); step("ld_96");
    drive(3'd0, 0, 1, 8'h00); step("shl");
    check("shl.q", 32'(q), 32'h2D);
    check("shl.sout", 32'(s_out), 32'h1);
    drive(3'd0, 1, 0, 8'h00); step("shr");
    check("shr.q", 32'(q), 32'h16);
    check("shr.sout", 32'(s_out), 32'h1);

    drive(3'd2, 0, 0, 8'h81); step("ld_81");
    drive(3'd1, 0, 0, 8'h00); step("rotl");
    check("rotl.q", 32'(q), 32'h03);
    drive(3'd1, 1, 0, 8'h00); step("rotr"); step("rotr");
    check("rotr2.q", 32'(q), 32'hC0);
    drive(3'd2, 0, 0, 8'h80); step("ld_80");
    drive(3'd4, 1, 1, 8'h00); step("asr");
    check("asr.q", 32'(q), 32'hC0);
    check("asr.sout", 32'(s_out), 32'h0);
    drive(3'd3, 0, 0, 8'h00); step("clr");
    check("clr.q", 32'(q), 32'h0);

    // serialise B4 MSB-first
    drive(3'd2, 0, 0, 8'hB4); step("ld_b4");
    drive(3'd5, 0, 0, 8'h00); cnt = 4'd8; start = 1; step("ser_go");
    check("ser.busy0", 32'(busy), 32'h1);
    start = 0; modo = 3'd6; dir = 1; s_in = 1;
    bits = 8'hB4;
    for (int k = 0; k < 8; k++) begin
      check("ser.busy", 32'(busy), 32'h1);
      s_in = 0;
      step("ser");
      check("ser.bit", 32'(s_out), 32'(bits[7-k]));
    end
    check("ser.end_busy", 32'(busy), 32'h0);
    check("ser.done", 32'(done), 32'h1);
    check("ser.q", 32'(q), 32'h0);
    step("ser_after");
    check("ser.done_pulse", 32'(done), 32'h0);

    // ENB low for 2 cycles stretches the burst by 2
    drive(3'd2, 0, 0, 8'hB4); step("ld_b4b");
    drive(3'd5, 0, 0, 8'h00); cnt = 4'd8; start = 1; step("enb_go");
    start = 0; nb = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      nb++;
      enb = !(k == 3 || k == 4);
      step("enb_run");
    end
    enb = 1;
    check("enb.busy_cycles", 32'(nb), 32'd10);
    check("enb.done", 32'(done), 32'h1);

    // zero-length burst
    drive(3'd2, 0, 0, 8'h5A); step("ld_5a");
    drive(3'd5, 0, 0, 8'h00); cnt = 4'd0; start = 1; step("cnt0");
    check("cnt0.done", 32'(done), 32'h1);
    check("cnt0.busy", 32'(busy), 32'h0);
    check("cnt0.q", 32'(q), 32'h5A);
    start = 0; modo = 3'd6; step("cnt0_after");
    check("cnt0.pulse", 32'(done), 32'h0);

    // LOAD and START ignored while running
    drive(3'd2, 0, 0, 8'h0F); step("ld_0f");
    drive(3'd5, 1, 1, 8'h00); cnt = 4'd3; start = 1; step("run_go");
    drive(3'd2, 0, 1, 8'hFF); start = 1; cnt = 4'd9; step("run_ld");
    check("run_ld.q", 32'(q), 32'h87);
    repeat (3) step("run_tail");
    start = 0;

    // randomised traffic
    for (int i = 0; i < 2000; i++) begin
      modo  = 3'($urandom_range(0, 7));
      dir   = 1'($urandom_range(0, 1));
      s_in  = 1'($urandom_range(0, 1));
      d     = W'($urandom);
      cnt   = CW'($urandom_range(0, 15));
      start = ($urandom_range(0, 2) != 0);
      enb   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end
endmodule

// File: doc/universal_shift_register_n.md
Name: universal_shift_register_n

Overview:
- Parametrised universal shift register: logical shift, circular rotate, arithmetic shift, parallel load, synchronous clear, and an autonomous multi-cycle burst shift.
- Burst shift uses a START/BUSY/DONE handshake.
- Serves as the generic serialiser/deserialiser and data-alignment register for datapaths wider than 4 bits.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- CNT_W, 4, width of the burst-count input and internal counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- ENB  in  1  global enable; low freezes all state, including any burst in progress
- DIR  in  1  0 = left (towards MSB), 1 = right (towards LSB)
- S_IN  in  1  serial input bit
- MODO  in  3  operation select
- D  in  WIDTH  parallel load data
- CNT  in  CNT_W  burst length in shifts
- START  in  1  burst request, sampled in mode BURST only
- Q  out  WIDTH  parallel output, registered
- S_OUT  out  1  serial output, registered
- BUSY  out  1  high while a burst is running
- DONE  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (RST_N low, asynchronous): Q=0, S_OUT=0, BUSY=0, DONE=0, FSM=IDLE, counter=0.
- All updates occur on the CLK rising edge. Output latency is 1 cycle.
- ENB=0: every register holds its value, including the counter and FSM state. DONE also holds, so a pending pulse is stretched until ENB returns high.
- FSM states:
  - IDLE: MODO executes as decoded below.
  - RUN: MODO and START are ignored. Each enabled cycle performs one logical shift in the DIR direction, latched at START, using S_IN; the counter decrements. When the counter reaches 1 and that shift is performed, next state = IDLE, BUSY=0, DONE=1 for one cycle.
- MODO decode in IDLE, ENB=1 (DONE=0 unless stated otherwise):
  - 000 SHIFT:
    - Left: S_OUT<=Q[WIDTH-1], Q<={Q[WIDTH-2:0],S_IN}.
    - Right: S_OUT<=Q[0], Q<={S_IN,Q[WIDTH-1:1]}.
  - 001 ROTATE: left Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; right Q<={Q[0],Q[WIDTH-1:1]}. S_OUT<=0.
  - 010 LOAD: Q<=D, S_OUT<=0.
  - 011 CLEAR: Q<=0, S_OUT<=0.
  - 100 ARITH:
    - Left: shifts in 0; S_OUT<=Q[WIDTH-1].
    - Right: Q<={Q[WIDTH-1],Q[WIDTH-1:1]} (sign held); S_OUT<=Q[0].
  - 101 BURST:
    - START=1 with CNT>0: latch CNT into the counter and DIR into the burst direction; BUSY<=1; go to RUN. Q is unchanged this cycle.
    - START=1 with CNT=0: no shift; DONE<=1 next cycle; stay in IDLE.
    - START=0: hold.
  - 110, 111: hold Q and S_OUT.
- Burst shift semantics: S_OUT follows the SHIFT-mode rule every RUN cycle, giving an MSB-first (left) or LSB-first (right) bitstream.
- CNT > WIDTH is legal: bits continue shifting from S_IN.
- DIR changes during RUN are ignored.
- START while BUSY is ignored; no queuing.
- BUSY is high from the cycle after the accepted START through the last shift cycle. DONE asserts in the cycle BUSY falls.
- Reset asserted mid-burst aborts immediately to the reset values. No DONE is generated.

Optional Feature:
- Macro SHREG_PARITY_EN.
- Defined: adds output PARITY (1 bit), registered, equal to the XOR-reduce of the next Q value. It updates in the same edge as Q, so PARITY always equals ^Q. Reset value is 0.
- Not defined: no PARITY port and no parity logic.

Test Plan:
- Reset mid-burst: LOAD D=8'hA5, BURST START CNT=8, assert RST_N=0 after 3 cycles -> Q=0, BUSY=0, DONE never pulses.
- LOAD D=8'h96, then SHIFT DIR=0 S_IN=1 -> Q=8'h2D, S_OUT=1. Then SHIFT DIR=1 S_IN=0 -> Q=8'h16, S_OUT=1.
- LOAD 8'h81:
  - ROTATE left -> 8'h03.
  - ROTATE right twice -> 8'hC0.
  - ARITH right on 8'h80 -> 8'hC0, S_OUT=0.
  - CLEAR -> Q=0.
- Serialise: LOAD 8'hB4, BURST DIR=0 S_IN=0 CNT=8 START=1 -> BUSY high 8 cycles, S_OUT sequence 1,0,1,1,0,1,0,0, then Q=0 and a DONE pulse. ENB low 2 cycles mid-burst -> burst extends by exactly 2 cycles.
- Edge cases:
  - CNT=0 START -> DONE next cycle, Q unchanged, BUSY stays 0.
  - START and MODO=LOAD during RUN -> Q continues shifting; D ignored.
